// File: rtl/cordic_pkg.sv
// Shared constants, FSM state type and arctangent table for the CORDIC arbiter.
// All angles are signed Q16.16 degrees.
package cordic_pkg;

   localparam int Q_W = 32;
   localparam logic signed [Q_W-1:0] K_GAIN        = 32'sd39797;
   localparam logic signed [Q_W-1:0] ANG_MAX_DEG90 = 32'sd5898240;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // atan(2^-idx) in Q16.16 degrees
   function automatic logic signed [Q_W-1:0] atan_lut(input logic [3:0] idx);
      logic signed [Q_W-1:0] val;
      case (idx)
         4'd0:    val = 32'sd2949120;
         4'd1:    val = 32'sd1740970;
         4'd2:    val = 32'sd919876;
         4'd3:    val = 32'sd466944;
         4'd4:    val = 32'sd234376;
         4'd5:    val = 32'sd117302;
         4'd6:    val = 32'sd58667;
         4'd7:    val = 32'sd29333;
         4'd8:    val = 32'sd14666;
         4'd9:    val = 32'sd7333;
         4'd10:   val = 32'sd3670;
         4'd11:   val = 32'sd1835;
         4'd12:   val = 32'sd917;
         default: val = 32'sd0;
      endcase
      return val;
   endfunction

endpackage

// File: rtl/cordic_step.sv
// One combinational CORDIC micro-rotation in rotation mode: rotates (x,y)
// toward the residual angle z by atan(2^-i).
module cordic_step
   import cordic_pkg::*;
(
   input  logic signed [31:0] x_i,
   input  logic signed [31:0] y_i,
   input  logic signed [31:0] z_i,
   input  logic [3:0]         i_i,
   output logic signed [31:0] x_o,
   output logic signed [31:0] y_o,
   output logic signed [31:0] z_o
);

   logic signed [31:0] x_sh_s;
   logic signed [31:0] y_sh_s;
   logic signed [31:0] atan_s;

   assign x_sh_s = x_i >>> i_i;
   assign y_sh_s = y_i >>> i_i;
   assign atan_s = atan_lut(i_i);

   // Rotation direction follows the sign of the residual angle
   always_comb begin
      x_o = x_i;
      y_o = y_i;
      z_o = z_i;
      if (z_i >= 32'sd0) begin
         x_o = x_i - y_sh_s;
         y_o = y_i + x_sh_s;
         z_o = z_i - atan_s;
      end else begin
         x_o = x_i + y_sh_s;
         y_o = y_i - x_sh_s;
         z_o = z_i + atan_s;
      end
   end

endmodule

// File: rtl/cordic_arbiter.sv
// Two-requester round-robin front end to a single iterative CORDIC sin/cos
// engine; one request in flight at a time, result held until consumed.
module cordic_arbiter
   import cordic_pkg::*;
#(
   parameter int                 ITER    = 13,
   parameter logic signed [31:0] ANG_MAX = ANG_MAX_DEG90
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_angle,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_angle,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_cos,
   output logic [31:0] rsp_sin,
   output logic        rsp_tag,
   output logic        rsp_err,
   output logic        busy
);

   localparam logic [3:0] LAST_I = 4'(ITER - 1);

   state_e             state_q, state_d;
   logic               last_q, last_d;
   logic signed [31:0] x_q, x_d;
   logic signed [31:0] y_q, y_d;
   logic signed [31:0] z_q, z_d;
   logic [3:0]         i_q, i_d;
   logic               tag_q, tag_d;
   logic               err_q, err_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;

   logic               grant_s;
   logic               accept_s;
   logic signed [31:0] angle_s;
   logic               range_bad_s;
   logic signed [31:0] x_nx_s;
   logic signed [31:0] y_nx_s;
   logic signed [31:0] z_nx_s;

   cordic_step u_step (
      .x_i (x_q),
      .y_i (y_q),
      .z_i (z_q),
      .i_i (i_q),
      .x_o (x_nx_s),
      .y_o (y_nx_s),
      .z_o (z_nx_s)
   );

   // Grant and next-state logic
   always_comb begin
      state_d     = state_q;
      last_d      = last_q;
      x_d         = x_q;
      y_d         = y_q;
      z_d         = z_q;
      i_d         = i_q;
      tag_d       = tag_q;
      err_d       = err_q;
      valid_d     = valid_q;
      busy_d      = busy_q;
      grant_s     = 1'b0;
      accept_s    = 1'b0;
      angle_s     = $signed(req0_angle);
      range_bad_s = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0_valid && req1_valid) begin
               grant_s = ~last_q;
            end else if (req1_valid) begin
               grant_s = 1'b1;
            end else begin
               grant_s = 1'b0;
            end
            accept_s    = grant_s ? req1_valid : req0_valid;
            angle_s     = grant_s ? $signed(req1_angle) : $signed(req0_angle);
            range_bad_s = (angle_s > ANG_MAX) || (angle_s < -ANG_MAX);
            if (accept_s) begin
               tag_d  = grant_s;
               last_d = grant_s;
               y_d    = 32'sd0;
               z_d    = angle_s;
               i_d    = 4'd0;
               busy_d = 1'b1;
               if (range_bad_s) begin
                  x_d     = 32'sd0;
                  err_d   = 1'b1;
                  valid_d = 1'b1;
                  state_d = DONE;
               end else begin
                  x_d     = K_GAIN;
                  err_d   = 1'b0;
                  valid_d = 1'b0;
                  state_d = RUN;
               end
            end else begin
               busy_d = 1'b0;
            end
         end
         RUN: begin
            x_d = x_nx_s;
            y_d = y_nx_s;
            z_d = z_nx_s;
            i_d = i_q + 4'd1;
            if (i_q == LAST_I) begin
               valid_d = 1'b1;
               state_d = DONE;
            end else begin
               valid_d = 1'b0;
            end
         end
         DONE: begin
            if (rsp_ready) begin
               valid_d = 1'b0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               valid_d = 1'b1;
            end
         end
         default: begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; last_q resets to 1 so req0 wins the first tie
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         x_q     <= 32'sd0;
         y_q     <= 32'sd0;
         z_q     <= 32'sd0;
         i_q     <= 4'd0;
         tag_q   <= 1'b0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         x_q     <= x_d;
         y_q     <= y_d;
         z_q     <= z_d;
         i_q     <= i_d;
         tag_q   <= tag_d;
         err_q   <= err_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
      end
   end

   assign req0_ready = (state_q == IDLE) && !grant_s;
   assign req1_ready = (state_q == IDLE) && grant_s;
   assign rsp_valid  = valid_q;
   assign rsp_cos    = x_q;
   assign rsp_sin    = y_q;
   assign rsp_tag    = tag_q;
   assign rsp_err    = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed self-checking bench for cordic_arbiter: vector table plus
// hand-written sequences for arbitration, hold, and mid-run reset.
module tb_cordic_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        req0_valid, req1_valid;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_angle, req1_angle;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_cos, rsp_sin;
   logic        rsp_tag, rsp_err, busy;

   int checks = 0;
   int errors = 0;

   localparam int TOL = 64;

   typedef struct {
      logic               sel;
      logic signed [31:0] angle;
      int                 exp_lat;
      int                 exp_cos;
      int                 exp_sin;
      int                 exp_err;
   } vec_t;

   vec_t vecs [8];

   cordic_arbiter dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_angle (req0_angle),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_angle (req1_angle),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_cos    (rsp_cos),
      .rsp_sin    (rsp_sin),
      .rsp_tag    (rsp_tag),
      .rsp_err    (rsp_err),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk_eq(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_tol(input string nm, input int act, input int exp);
      int diff;
      checks++;
      diff = act - exp;
      if (diff < 0) diff = -diff;
      if (diff > TOL) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d +/- %0d", nm, act, exp, TOL);
      end
   endtask

   // Waits (bounded) for rsp_valid, counting edges after the accept edge
   task automatic wait_rsp(output int lat);
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (rsp_valid) break;
      end
   endtask

   task automatic consume();
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk_eq("release_valid", int'(rsp_valid), 0);
      chk_eq("release_busy", int'(busy), 0);
   endtask

   task automatic do_req(input logic sel, input logic signed [31:0] ang,
                         output int lat, output int c, output int s,
                         output int t, output int e);
      @(posedge clk); #1;
      if (sel) begin
         req1_valid = 1'b1; req1_angle = ang;
      end else begin
         req0_valid = 1'b1; req0_angle = ang;
      end
      #1;
      chk_eq("ready_pre", int'(sel ? req1_ready : req0_ready), 1);
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      wait_rsp(lat);
      c = $signed(rsp_cos);
      s = $signed(rsp_sin);
      t = int'(rsp_tag);
      e = int'(rsp_err);
      consume();
   endtask

   initial begin
      int lat, c, s, t, e, bad, rises;
      int h_cos, h_sin, h_tag, h_err;

      vecs[0] = '{1'b0, 32'sd0,         13, 65536,  0,      0};
      vecs[1] = '{1'b1, 32'sd1966080,   13, 56756,  32768,  0};
      vecs[2] = '{1'b1, -32'sd2949120,  13, 46341,  -46341, 0};
      vecs[3] = '{1'b0, 32'sd6553600,   1,  0,      0,      1};
      vecs[4] = '{1'b0, 32'sd5898240,   13, 0,      65536,  0};
      vecs[5] = '{1'b1, 32'sd5898241,   1,  0,      0,      1};
      vecs[6] = '{1'b1, -32'sd5898240,  13, 0,      -65536, 0};
      vecs[7] = '{1'b0, -32'sd6553600,  1,  0,      0,      1};

      rst = 1'b1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      req0_angle = 32'd0; req1_angle = 32'd0;
      rsp_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("rst_valid", int'(rsp_valid), 0);
      chk_eq("rst_cos", int'(rsp_cos), 0);
      chk_eq("rst_sin", int'(rsp_sin), 0);
      chk_eq("rst_tag", int'(rsp_tag), 0);
      chk_eq("rst_err", int'(rsp_err), 0);
      chk_eq("rst_busy", int'(busy), 0);
      rst = 1'b0;

      // Tie right after reset: req0 first, then req1, then back to req0
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_angle = 32'd0;
      req1_valid = 1'b1; req1_angle = 32'd1966080;
      #1;
      chk_eq("tie_req0_ready", int'(req0_ready), 1);
      chk_eq("tie_req1_ready", int'(req1_ready), 0);
      @(posedge clk); #1;
      req0_angle = 32'd12345678;
      bad = 0;
      lat = 0;
      while (lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (req0_ready || req1_ready) bad++;
         if (rsp_valid) break;
      end
      chk_eq("tie_ready_low_busy", bad, 0);
      chk_eq("tie0_lat", lat, 13);
      chk_eq("tie0_tag", int'(rsp_tag), 0);
      chk_tol("tie0_cos", $signed(rsp_cos), 65536);
      chk_tol("tie0_sin", $signed(rsp_sin), 0);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk_eq("tie_req1_ready_idle", int'(req1_ready), 1);
      chk_eq("tie_req0_ready_idle", int'(req0_ready), 0);
      @(posedge clk); #1;
      req0_angle = 32'd0;
      wait_rsp(lat);
      chk_eq("tie1_lat", lat, 13);
      chk_eq("tie1_tag", int'(rsp_tag), 1);
      chk_tol("tie1_cos", $signed(rsp_cos), 56756);
      chk_tol("tie1_sin", $signed(rsp_sin), 32768);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk_eq("tie_rr_req0_ready", int'(req0_ready), 1);
      chk_eq("tie_rr_req1_ready", int'(req1_ready), 0);
      req0_valid = 1'b0; req1_valid = 1'b0;

      for (int k = 0; k < 8; k++) begin
         do_req(vecs[k].sel, vecs[k].angle, lat, c, s, t, e);
         chk_eq($sformatf("v%0d_lat", k), lat, vecs[k].exp_lat);
         chk_eq($sformatf("v%0d_tag", k), t, int'(vecs[k].sel));
         chk_eq($sformatf("v%0d_err", k), e, vecs[k].exp_err);
         if (vecs[k].exp_err != 0) begin
            chk_eq($sformatf("v%0d_cos", k), c, 0);
            chk_eq($sformatf("v%0d_sin", k), s, 0);
         end else begin
            chk_tol($sformatf("v%0d_cos", k), c, vecs[k].exp_cos);
            chk_tol($sformatf("v%0d_sin", k), s, vecs[k].exp_sin);
         end
      end

      // Result held for 10 cycles with rsp_ready low
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_angle = 32'd1966080;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_rsp(lat);
      chk_eq("hold_lat", lat, 13);
      h_cos = $signed(rsp_cos);
      h_sin = $signed(rsp_sin);
      h_tag = int'(rsp_tag);
      h_err = int'(rsp_err);
      bad = 0;
      for (int k = 0; k < 10; k++) begin
         @(posedge clk); #1;
         if (!rsp_valid || !busy || $signed(rsp_cos) != h_cos ||
             $signed(rsp_sin) != h_sin || int'(rsp_tag) != h_tag ||
             int'(rsp_err) != h_err) bad++;
      end
      chk_eq("hold_stable", bad, 0);
      chk_tol("hold_cos", h_cos, 56756);
      consume();

      // Reset pulsed mid-RUN aborts the operation
      @(posedge clk); #1;
      req1_valid = 1'b1; req1_angle = 32'd2949120;
      @(posedge clk); #1;
      req1_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk_eq("midrun_busy_before", int'(busy), 1);
      rst = 1'b1;
      #1;
      chk_eq("midrun_rst_busy", int'(busy), 0);
      chk_eq("midrun_rst_valid", int'(rsp_valid), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      rises = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk); #1;
         if (rsp_valid) rises++;
      end
      chk_eq("midrun_no_rsp", rises, 0);
      do_req(1'b0, -32'sd1966080, lat, c, s, t, e);
      chk_eq("post_rst_lat", lat, 13);
      chk_eq("post_rst_tag", t, 0);
      chk_eq("post_rst_err", e, 0);
      chk_tol("post_rst_cos", c, 56756);
      chk_tol("post_rst_sin", s, -32768);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
